// File: rtl/turn_scheduler_pkg.sv
// Shared state encodings and id/round types for the turn scheduler.
package turn_scheduler_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StReady    = 3'd0;
   localparam state_t StTurnInit = 3'd1;
   localparam state_t StAdvance  = 3'd2;
   localparam state_t StInRound  = 3'd3;
   localparam state_t StGameOver = 3'd6;

   localparam int unsigned PlayerW = 3;
   localparam int unsigned RoundW  = 12;

   typedef logic [PlayerW-1:0] player_t;
   typedef logic [RoundW-1:0]  round_t;

   // Player 0 is the NPC and is never scheduled.
   localparam player_t NPC_ID = '0;

endpackage

// File: rtl/turn_scheduler_player_ring_search.sv
// Combinational circular search for the next alive player after from_id_i.
module player_ring_search #(
   parameter int unsigned MAX_PLAYER_CNT      = 7,
   parameter int unsigned LOG2_MAX_PLAYER_CNT = 3
) (
   input  logic [MAX_PLAYER_CNT-1:0]      alive_i,
   input  logic [LOG2_MAX_PLAYER_CNT-1:0] from_id_i,
   output logic [LOG2_MAX_PLAYER_CNT-1:0] next_id_o,
   output logic                           found_o
);

   int unsigned               cand;
   logic [MAX_PLAYER_CNT-1:0] alive_shift;

   // Candidates from_id+1..MAX then 1..from_id; from_id 0 yields the lowest alive id.
   always_comb begin
      next_id_o   = from_id_i;
      found_o     = 1'b0;
      cand        = 0;
      alive_shift = '0;
      for (int unsigned k = 1; k <= MAX_PLAYER_CNT; k++) begin
         cand = 32'(from_id_i) + k;
         if (cand > MAX_PLAYER_CNT) begin
            cand = cand - MAX_PLAYER_CNT;
         end
         alive_shift = alive_i >> (cand - 1);
         if (!found_o && cand >= 1 && cand <= MAX_PLAYER_CNT && alive_shift[0]) begin
            found_o   = 1'b1;
            next_id_o = LOG2_MAX_PLAYER_CNT'(cand);
         end
      end
   end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: player rotation, per-turn countdown, round counter and winner detection.
// Optional TURN_SCHEDULER_PAUSE_EN adds a `pause` input that freezes the turn timer.
module turn_scheduler
   import turn_scheduler_pkg::*;
#(
   parameter int unsigned MAX_PLAYER_CNT      = 7,
   parameter int unsigned LOG2_MAX_PLAYER_CNT = 3,
   parameter int unsigned MAX_STEP_TIME       = 15,
   parameter int unsigned LOG2_MAX_STEP_TIME  = 4,
   parameter int unsigned MAX_ROUND           = 999,
   parameter int unsigned LOG2_MAX_ROUND      = 12,
   parameter int unsigned TICKS_PER_SEC       = 50_000_000
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [LOG2_MAX_PLAYER_CNT-1:0] first_player,
   input  logic [MAX_PLAYER_CNT-1:0]      alive,
   input  logic                           step_done,
`ifdef TURN_SCHEDULER_PAUSE_EN
   input  logic                           pause,
`endif
   output logic [2:0]                     state,
   output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
   output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
   output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
   output logic [LOG2_MAX_ROUND-1:0]      round,
   output logic                           turn_start,
   output logic                           timeout,
   output logic                           game_over,
   output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

   localparam int unsigned PW    = LOG2_MAX_PLAYER_CNT;
   localparam int unsigned TW    = LOG2_MAX_STEP_TIME;
   localparam int unsigned RW    = LOG2_MAX_ROUND;
   localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_SEC - 1);

   state_t            state_q, state_d;
   logic [PW-1:0]     cur_q, cur_d;
   logic [PW-1:0]     next_q, next_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [RW-1:0]     round_q, round_d;
   logic [TickW-1:0]  tick_q, tick_d;
   logic              start_q;
   logic              turn_start_q, turn_start_d;
   logic              timeout_q, timeout_d;
   logic [PW-1:0]     winner_q, winner_d;

   logic                      start_rise;
   logic                      run;
   int unsigned               alive_cnt;
   logic [MAX_PLAYER_CNT-1:0] cur_shift;
   logic [MAX_PLAYER_CNT-1:0] first_shift;
   logic                      cur_alive;
   logic                      first_valid;
   logic [PW-1:0]             search_from;
   logic [PW-1:0]             rs_id;
   logic                      rs_found;

`ifdef TURN_SCHEDULER_PAUSE_EN
   assign run = ~pause;
`else
   assign run = 1'b1;
`endif

   assign start_rise = start & ~start_q;

   always_comb begin
      alive_cnt = 0;
      for (int unsigned i = 0; i < MAX_PLAYER_CNT; i++) begin
         alive_cnt = alive_cnt + 32'(alive[i]);
      end
   end

   assign cur_shift   = alive >> (cur_q - PW'(1));
   assign cur_alive   = (cur_q != NPC_ID) && cur_shift[0];
   assign first_shift = alive >> (first_player - PW'(1));
   assign first_valid = (first_player != NPC_ID) &&
                        (32'(first_player) <= MAX_PLAYER_CNT) && first_shift[0];

   // READY searches from the NPC id to get the lowest alive player.
   assign search_from = (state_q == StReady) ? NPC_ID : cur_q;

   player_ring_search #(
      .MAX_PLAYER_CNT      (MAX_PLAYER_CNT),
      .LOG2_MAX_PLAYER_CNT (LOG2_MAX_PLAYER_CNT)
   ) u_ring_search (
      .alive_i   (alive),
      .from_id_i (search_from),
      .next_id_o (rs_id),
      .found_o   (rs_found)
   );

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      next_d       = next_q;
      timer_d      = timer_q;
      round_d      = round_q;
      tick_d       = tick_q;
      winner_d     = winner_q;
      turn_start_d = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         StReady: begin
            if (start_rise) begin
               if (alive_cnt <= 1) begin
                  state_d  = StGameOver;
                  winner_d = rs_found ? rs_id : NPC_ID;
               end else begin
                  cur_d   = first_valid ? first_player : rs_id;
                  round_d = RW'(1);
                  state_d = StTurnInit;
               end
            end
         end
         StTurnInit: begin
            timer_d      = TW'(MAX_STEP_TIME);
            tick_d       = '0;
            next_d       = rs_id;
            turn_start_d = 1'b1;
            state_d      = StInRound;
         end
         StInRound: begin
            // A committed move or an eliminated current player ends the turn without timeout.
            if (!cur_alive || step_done) begin
               state_d = StAdvance;
            end else if (run) begin
               if (tick_q == TickMax) begin
                  tick_d = '0;
                  if (timer_q <= TW'(1)) begin
                     timer_d   = '0;
                     timeout_d = 1'b1;
                     state_d   = StAdvance;
                  end else begin
                     timer_d = timer_q - TW'(1);
                  end
               end else begin
                  tick_d = tick_q + TickW'(1);
               end
            end
         end
         StAdvance: begin
            if (alive_cnt <= 1) begin
               state_d  = StGameOver;
               winner_d = rs_found ? rs_id : NPC_ID;
            end else if (rs_id <= cur_q && round_q == RW'(MAX_ROUND)) begin
               state_d  = StGameOver;
               winner_d = NPC_ID;
            end else begin
               if (rs_id <= cur_q) begin
                  round_d = round_q + RW'(1);
               end
               cur_d   = rs_id;
               state_d = StTurnInit;
            end
         end
         StGameOver: begin
            state_d = StGameOver;
         end
         default: begin
            state_d = StReady;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StReady;
         cur_q        <= '0;
         next_q       <= '0;
         timer_q      <= '0;
         round_q      <= '0;
         tick_q       <= '0;
         start_q      <= 1'b0;
         turn_start_q <= 1'b0;
         timeout_q    <= 1'b0;
         winner_q     <= '0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         next_q       <= next_d;
         timer_q      <= timer_d;
         round_q      <= round_d;
         tick_q       <= tick_d;
         start_q      <= start;
         turn_start_q <= turn_start_d;
         timeout_q    <= timeout_d;
         winner_q     <= winner_d;
      end
   end

   assign state          = state_q;
   assign current_player = cur_q;
   assign next_player    = next_q;
   assign step_timer     = timer_q;
   assign round          = round_q;
   assign turn_start     = turn_start_q;
   assign timeout        = timeout_q;
   assign game_over      = (state_q == StGameOver);
   assign winner         = winner_q;

endmodule
